out_buf_arbiter: RTL
====================

# out_buf_arbiter

Shares the single UART transmit output buffer between up to N_REQ command handlers, each of which presents a response word, byte count and ready flag. Selects one pending handler round-robin, latches its response, hands it to the buffer with a one-cycle `out_rdy` strobe, and holds ownership until the buffer has drained. Sits between the command handlers and the output buffer, replacing a direct handler-to-buffer connection.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 256, response word width
- `BC_W`, 4, byte-count width
- `TIMEOUT`, 15, cycles allowed for buffer to assert busy after strobe (macro only)

Ports:
- `clk` in 1: clock; all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `req_out` in N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W]
- `req_bytecount` in N_REQ*BC_W: requester i occupies bits [i*BC_W +: BC_W]
- `req_rdy` in N_REQ: level request; held high by handler until it is disabled
- `req_busy` out N_REQ: per-requester "buffer not available to you"
- `req_done` out N_REQ: one-cycle pulse when requester's transfer has drained
- `grant` out N_REQ: one-hot owner, high for whole transfer
- `out` out DATA_W: latched response to buffer
- `out_bytecount` out BC_W: latched byte count to buffer
- `out_rdy` out 1: one-cycle load strobe to buffer
- `out_buf_busy` in 1: buffer busy transmitting
- `err` out 1: one-cycle timeout pulse

## Operation
- Reset: state IDLE; `out`, `out_bytecount`, `out_rdy`, `grant`, `req_done`, `err` = 0; `req_busy` = 0; priority pointer = 0; all served flags cleared.
- Served flag per requester: set when its transfer completes (or times out) while its `req_rdy` is still high; cleared in any cycle its `req_rdy` is 0. Pending(i) = `req_rdy[i]` & ~served[i]. One response per `req_rdy` assertion.
- States:
  - IDLE: if `out_buf_busy`=0 and any pending, winner w = first pending index at or after pointer, wrapping mod N_REQ. Latch `out`/`out_bytecount` from w, set `grant[w]`, go LOAD.
  - LOAD: `out_rdy`=1 this cycle only; go WAIT_BUSY.
  - WAIT_BUSY: on `out_buf_busy`=1 go DRAIN.
  - DRAIN: on `out_buf_busy`=0 pulse `req_done[w]`, set served[w] if `req_rdy[w]`, pointer = (w+1) mod N_REQ, clear `grant`, go IDLE.
- `req_busy[i]` = (state ≠ IDLE) | `out_buf_busy` | served[i] (combinational).
- Requester dropping `req_rdy` mid-transfer: transfer completes from latched data; `req_done` still pulses; served not set.
- `out`/`out_bytecount` hold last latched value until next grant; byte count forwarded unmodified (0 allowed).

## Timing
- `req_rdy[i]` high at edge n with IDLE, buffer idle, i winning -> `grant[i]` high after edge n; `out_rdy` high during cycle after edge n+1 for exactly one cycle.
- Buffer busy seen at edge m in WAIT_BUSY -> DRAIN after m; busy low at edge k in DRAIN -> `req_done` pulse and IDLE after k.
- Minimum spacing between consecutive `out_rdy` strobes: 4 cycles.
- Simultaneous requests: exactly one grant; others wait, serviced in round-robin order.
- Reset mid-operation: all outputs 0 after the reset edge; in-flight transfer abandoned, no `req_done`.

## Configuration
- `OUT_BUF_ARB_TIMEOUT_EN` defined: WAIT_BUSY counts cycles; if `out_buf_busy` not seen within TIMEOUT cycles after LOAD, pulse `err` one cycle, set served[w] if `req_rdy[w]`, advance pointer, clear `grant`, return IDLE, no `req_done`.
- Not defined: WAIT_BUSY waits indefinitely; `err` tied 0; no counter.

## Test plan
- Single request: `req_rdy`=0001, `req_out[0]`=16'hfefe, bytecount 1, busy raised 1 cycle after strobe for 5 cycles -> one `out_rdy` pulse, `out`=16'hfefe, `out_bytecount`=1, `grant`=0001, `req_done[0]` pulse; no second strobe while `req_rdy[0]` stays high.
- Simultaneous `req_rdy`=1011 after reset -> grant order 0, 1, 3; each `out` matches its requester; three strobes total.
- Fairness: requesters 0 and 2 re-assert `req_rdy` immediately after each `req_done` -> grants alternate 0, 2, 0, 2.
- `out_buf_busy`=1 externally during IDLE with pending request -> no grant until busy low; `req_busy` all 1.
- Reset asserted in DRAIN -> `grant`, `out_rdy`, `out` = 0 next cycle; no `req_done`; pointer 0.
- With `OUT_BUF_ARB_TIMEOUT_EN`, TIMEOUT=15, busy never asserted -> `err` pulses once, IDLE, next pending requester granted; without macro, arbiter stays in WAIT_BUSY.

Source files
------------

// File: rtl/out_buf_arbiter.sv
// out_buf_arbiter: round-robin owner of the shared UART output buffer; define OUT_BUF_ARB_TIMEOUT_EN for the busy-handshake timeout
module out_buf_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 256,
  parameter int BC_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_out,
  input  logic [N_REQ*BC_W-1:0]   req_bytecount,
  input  logic [N_REQ-1:0]        req_rdy,
  output logic [N_REQ-1:0]        req_busy,
  output logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       out,
  output logic [BC_W-1:0]         out_bytecount,
  output logic                    out_rdy,
  input  logic                    out_buf_busy,
  output logic                    err
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, DRAIN} state_t;
  state_t state, state_n;
  logic [N_REQ-1:0] served, pending;
  logic [IW-1:0] ptr, widx, win;
  logic any, finish, tout;
  assign pending = req_rdy & ~served;
  assign req_busy = {N_REQ{state != IDLE || out_buf_busy}} | served;
`ifdef OUT_BUF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  assign tout = state == WAIT_BUSY && !out_buf_busy && cnt == TLAST;
  // cycles spent waiting for the buffer to acknowledge the strobe
  always_ff @(posedge clk) cnt <= (rst || state != WAIT_BUSY) ? '0 : cnt + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT > 0;
  assign tout = 1'b0;
`endif
  // first pending requester at or after the pointer; descending scan lets the nearest one win
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (pending[(int'(ptr) + k) % N_REQ]) begin
        win = IW'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
  end
  // next state; finish marks the end of ownership (drained or timed out)
  always_comb begin
    state_n = state;
    finish = 1'b0;
    case (state)
      IDLE: state_n = (!out_buf_busy && any) ? LOAD : IDLE;
      LOAD: state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        state_n = out_buf_busy ? DRAIN : tout ? IDLE : WAIT_BUSY;
        finish = !out_buf_busy && tout;
      end
      DRAIN: begin
        state_n = out_buf_busy ? DRAIN : IDLE;
        finish = !out_buf_busy;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // ownership, latched response, pulses, served flags and rotating pointer
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      widx <= '0;
      served <= '0;
      grant <= '0;
      out <= '0;
      out_bytecount <= '0;
      out_rdy <= 1'b0;
      req_done <= '0;
      err <= 1'b0;
    end else begin
      out_rdy <= state == LOAD;
      req_done <= (state == DRAIN && !out_buf_busy) ? grant : '0;
      err <= tout;
      served <= req_rdy & (served | (finish ? grant : '0));
      if (state == IDLE && state_n == LOAD) begin
        widx <= win;
        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        out <= req_out[int'(win)*DATA_W +: DATA_W];
        out_bytecount <= req_bytecount[int'(win)*BC_W +: BC_W];
      end else if (finish) begin
        grant <= '0;
        ptr <= (widx == IW'(N_REQ - 1)) ? '0 : widx + 1'b1;
      end
    end
endmodule
